// File: rtl/fir_out_formatter_pkg.sv
// Shared types and Q-format constants for the FIR output formatter.
package fir_fmt_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fmt_state_e;

    localparam int FRAC_SHIFT = 15;
    localparam int OUT_MAX    = 32767;
    localparam int OUT_MIN    = -32768;
    localparam int ROUND_BIAS = 1 << (FRAC_SHIFT - 1);

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit so full and empty differ.
module fir_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
        level    = wr_ptr_q - rd_ptr_q;
        dout     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fir_out_formatter.sv
// Discards filter warm-up samples, rounds/saturates to Q1.15, decimates and
// queues results for a valid/ready consumer.
module fir_out_formatter #(
    parameter int DATA_IN_WIDTH  = 32,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int FRAC_SHIFT     = fir_fmt_pkg::FRAC_SHIFT,
    parameter int PIPE_LAT       = 2,
    parameter int DEC_WIDTH      = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_fir_en,
    input  logic [DATA_IN_WIDTH-1:0]        i_fir_data,
    input  logic [DEC_WIDTH-1:0]            i_dec_factor,
    input  logic                            i_sat_clr,
    input  logic                            i_ready,
    output logic [DATA_OUT_WIDTH-1:0]       o_data,
    output logic                            o_valid,
    output logic                            o_sat_flag,
    output logic                            o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

    import fir_fmt_pkg::*;

    localparam int XW  = DATA_IN_WIDTH + 1;
    localparam int PCW = $clog2(PIPE_LAT + 1);
    localparam logic signed [XW-1:0]       BIAS_X = XW'(1 << (FRAC_SHIFT - 1));
    localparam logic signed [XW-1:0]       MAX_X  = XW'(OUT_MAX);
    localparam logic signed [XW-1:0]       MIN_X  = XW'(OUT_MIN);
    localparam logic [DATA_OUT_WIDTH-1:0]  MAX_O  = DATA_OUT_WIDTH'(OUT_MAX);
    localparam logic [DATA_OUT_WIDTH-1:0]  MIN_O  = DATA_OUT_WIDTH'(OUT_MIN);

    fmt_state_e                state_q, state_d;
    logic [PCW-1:0]            prime_cnt_q, prime_cnt_d;
    logic [DEC_WIDTH-1:0]      dec_cnt_q, dec_cnt_d;
    logic [DEC_WIDTH-1:0]      dec_lim_q, dec_lim_d;
    logic                      en_d_q, en_d_d;
    logic [DATA_OUT_WIDTH-1:0] smp_q, smp_d;
    logic                      push_q, push_d;
    logic                      sat_q, sat_d;
    logic                      ovf_q, ovf_d;

    logic signed [XW-1:0]      x_ext, r_val;
    logic [DATA_OUT_WIDTH-1:0] rounded;
    logic                      clip;
    logic [DEC_WIDTH-1:0]      lim_live, lim_use;
    logic                      fifo_full, fifo_empty, pop;

    always_comb begin
        x_ext   = {i_fir_data[DATA_IN_WIDTH-1], i_fir_data};
        r_val   = (x_ext + BIAS_X) >>> FRAC_SHIFT;
        clip    = (r_val > MAX_X) || (r_val < MIN_X);
        rounded = (r_val > MAX_X) ? MAX_O :
                  (r_val < MIN_X) ? MIN_O : r_val[DATA_OUT_WIDTH-1:0];
    end

    // The decimation limit is taken from i_dec_factor at the start of each period and held until the wrap.
    always_comb begin
        lim_live    = (i_dec_factor == '0) ? '0 : i_dec_factor - 1'b1;
        lim_use     = (dec_cnt_q == '0) ? lim_live : dec_lim_q;
        pop         = o_valid && i_ready;

        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        dec_cnt_d   = dec_cnt_q;
        dec_lim_d   = dec_lim_q;
        en_d_d      = i_fir_en;
        smp_d       = smp_q;
        push_d      = 1'b0;
        sat_d       = sat_q && !i_sat_clr;
        ovf_d       = ovf_q && !i_sat_clr;

        if (en_d_q) begin
            case (state_q)
                PRIME: begin
                    prime_cnt_d = prime_cnt_q + 1'b1;
                    if (prime_cnt_q == PCW'(PIPE_LAT - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    push_d    = (dec_cnt_q == '0);
                    smp_d     = rounded;
                    dec_lim_d = lim_use;
                    dec_cnt_d = (dec_cnt_q >= lim_use) ? '0 : dec_cnt_q + 1'b1;
                    if (clip) begin
                        sat_d = 1'b1;
                    end
                end
                default: state_d = PRIME;
            endcase
        end

        if (push_q && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= PRIME;
            prime_cnt_q <= '0;
            dec_cnt_q   <= '0;
            dec_lim_q   <= '0;
            en_d_q      <= 1'b0;
            smp_q       <= '0;
            push_q      <= 1'b0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            dec_lim_q   <= dec_lim_d;
            en_d_q      <= en_d_d;
            smp_q       <= smp_d;
            push_q      <= push_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
        end
    end

    fir_out_fifo #(
        .WIDTH (DATA_OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push_q),
        .pop     (pop),
        .din     (smp_q),
        .dout    (o_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_fifo_level)
    );

    assign o_valid    = !fifo_empty;
    assign o_sat_flag = sat_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fir_out_formatter.sv
// Directed bench for fir_out_formatter: vector table for rounding plus hand sequences.
module tb_fir_out_formatter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_fir_en = 1'b0;
    logic [31:0] i_fir_data = '0;
    logic [3:0]  i_dec_factor = 4'd1;
    logic        i_sat_clr = 1'b0;
    logic        i_ready = 1'b0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_sat_flag;
    logic        o_overflow;
    logic [2:0]  o_fifo_level;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    vec_t vecs[11];

    fir_out_formatter dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_fir_en     (i_fir_en),
        .i_fir_data   (i_fir_data),
        .i_dec_factor (i_dec_factor),
        .i_sat_clr    (i_sat_clr),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_sat_flag   (o_sat_flag),
        .o_overflow   (o_overflow),
        .o_fifo_level (o_fifo_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enable edge, then the filter output changes just after it, as the real filter does.
    task automatic applyStimulus(input logic [31:0] d, input logic clr);
        i_fir_en = 1'b1;
        tick();
        i_fir_data = d;
        i_fir_en = 1'b0;
        i_sat_clr = clr;
        tick();
        i_sat_clr = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic clear_flags();
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
    endtask

    task automatic reset_and_prime();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        applyStimulus(32'h0, 1'b0);
        applyStimulus(32'h0, 1'b0);
    endtask

    task automatic drain_check(input string name);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({name, "_valid"}, {31'h0, o_valid}, 32'h1);
            checkOutput({name, "_data"}, {16'h0, o_data}, exp_q[i] & 32'hFFFF);
            pop_one();
        end
        checkOutput({name, "_empty"}, {31'h0, o_valid}, 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0001_0000, 16'h0002, 1'b0};
        vecs[1]  = '{32'h0000_4000, 16'h0001, 1'b0};
        vecs[2]  = '{32'hFFFF_C000, 16'h0000, 1'b0};
        vecs[3]  = '{32'h0000_3FFF, 16'h0000, 1'b0};
        vecs[4]  = '{32'hFFFF_BFFF, 16'hFFFF, 1'b0};
        vecs[5]  = '{32'h4000_0000, 16'h7FFF, 1'b1};
        vecs[6]  = '{32'hC000_0000, 16'h8000, 1'b0};
        vecs[7]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
        vecs[8]  = '{32'h8000_0000, 16'h8000, 1'b1};
        vecs[9]  = '{32'h3FFF_8000, 16'h7FFF, 1'b0};
        vecs[10] = '{32'hFFFF_8000, 16'hFFFF, 1'b0};

        tick();
        tick();
        checkOutput("rst_data", {16'h0, o_data}, 32'h0);
        checkOutput("rst_valid", {31'h0, o_valid}, 32'h0);
        checkOutput("rst_sat", {31'h0, o_sat_flag}, 32'h0);
        checkOutput("rst_ovf", {31'h0, o_overflow}, 32'h0);
        checkOutput("rst_level", {29'h0, o_fifo_level}, 32'h0);
        i_rst_n = 1'b1;

        applyStimulus(32'h0001_0000, 1'b0);
        applyStimulus(32'h0001_0000, 1'b0);
        checkOutput("prime_valid", {31'h0, o_valid}, 32'h0);
        checkOutput("prime_level", {29'h0, o_fifo_level}, 32'h0);
        applyStimulus(32'h0001_0000, 1'b0);
        checkOutput("first_valid", {31'h0, o_valid}, 32'h1);
        checkOutput("first_data", {16'h0, o_data}, 32'h2);
        pop_one();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].din, 1'b0);
            checkOutput($sformatf("round%0d_valid", i), {31'h0, o_valid}, 32'h1);
            checkOutput($sformatf("round%0d_data", i), {16'h0, o_data}, {16'h0, vecs[i].dout});
            checkOutput($sformatf("round%0d_sat", i), {31'h0, o_sat_flag}, {31'h0, vecs[i].sat});
            pop_one();
            clear_flags();
            checkOutput($sformatf("round%0d_clr", i), {31'h0, o_sat_flag}, 32'h0);
        end

        applyStimulus(32'h4000_0000, 1'b1);
        checkOutput("sat_set_wins", {31'h0, o_sat_flag}, 32'h1);
        pop_one();
        clear_flags();

        i_dec_factor = 4'd3;
        reset_and_prime();
        for (int k = 1; k <= 9; k++) applyStimulus(32'(k) << 15, 1'b0);
        checkOutput("dec3_level", {29'h0, o_fifo_level}, 32'h3);
        exp_q = {1, 4, 7};
        drain_check("dec3");

        reset_and_prime();
        i_dec_factor = 4'd3;
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) i_dec_factor = 4'd2;
            applyStimulus(32'(k) << 15, 1'b0);
        end
        exp_q = {1, 4, 7, 9};
        drain_check("dec_chg");

        i_dec_factor = 4'd0;
        reset_and_prime();
        for (int k = 1; k <= 3; k++) applyStimulus(32'(k) << 15, 1'b0);
        exp_q = {1, 2, 3};
        drain_check("dec0");

        i_dec_factor = 4'd1;
        reset_and_prime();
        for (int k = 1; k <= 6; k++) applyStimulus(32'(k) << 15, 1'b0);
        checkOutput("bp_level", {29'h0, o_fifo_level}, 32'h4);
        checkOutput("bp_ovf", {31'h0, o_overflow}, 32'h1);
        exp_q = {1, 2, 3, 4};
        drain_check("bp");
        checkOutput("bp_ovf_sticky", {31'h0, o_overflow}, 32'h1);
        clear_flags();
        checkOutput("bp_ovf_clr", {31'h0, o_overflow}, 32'h0);

        for (int k = 1; k <= 4; k++) applyStimulus(32'(k) << 15, 1'b0);
        checkOutput("full_level", {29'h0, o_fifo_level}, 32'h4);
        i_fir_en = 1'b1;
        tick();
        i_fir_data = 32'(5) << 15;
        i_fir_en = 1'b0;
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checkOutput("pushpop_level", {29'h0, o_fifo_level}, 32'h4);
        checkOutput("pushpop_ovf", {31'h0, o_overflow}, 32'h0);
        exp_q = {2, 3, 4, 5};
        drain_check("pushpop");

        reset_and_prime();
        for (int k = 1; k <= 3; k++) applyStimulus(32'(k) << 15, 1'b0);
        checkOutput("mid_level", {29'h0, o_fifo_level}, 32'h3);
        i_rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_valid", {31'h0, o_valid}, 32'h0);
        checkOutput("mid_rst_level", {29'h0, o_fifo_level}, 32'h0);
        tick();
        i_rst_n = 1'b1;
        applyStimulus(32'(1) << 15, 1'b0);
        applyStimulus(32'(2) << 15, 1'b0);
        checkOutput("mid_prime_valid", {31'h0, o_valid}, 32'h0);
        applyStimulus(32'(3) << 15, 1'b0);
        checkOutput("mid_run_valid", {31'h0, o_valid}, 32'h1);
        checkOutput("mid_run_data", {16'h0, o_data}, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
